// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Optional feature macro: LOAD_USE_STALL_EN (enables hazard_stall logic).
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_read_data1,
    input  logic [XLEN-1:0]   id_read_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [3:0]        id_funct,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              hold,
    output logic [4:0]        ID_EX_Rs1,
    output logic [4:0]        ID_EX_Rs2,
    output logic [4:0]        ID_EX_Rd,
    output logic [XLEN-1:0]   ID_EX_ReadData1,
    output logic [XLEN-1:0]   ID_EX_ReadData2,
    output logic [XLEN-1:0]   ID_EX_Imm,
    output logic [XLEN-1:0]   ID_EX_PC,
    output logic [3:0]        ID_EX_Funct,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic              ID_EX_Valid,
    output logic              hazard_stall
);

    typedef struct packed {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [3:0]        funct;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } id_ex_t;

    id_ex_t stage_q;
    id_ex_t stage_d;
    id_ex_t incoming;

`ifdef LOAD_USE_STALL_EN
    logic rd_nz;
    logic rd_match;

    // Load in EX whose destination is a source of the ID instruction
    always_comb begin
        rd_nz        = (stage_q.rd != 5'd0);
        rd_match     = (stage_q.rd == id_rs1) | (stage_q.rd == id_rs2);
        hazard_stall = stage_q.valid & stage_q.ctrl[6] & rd_nz & rd_match;
    end
`else
    assign hazard_stall = 1'b0;
`endif

    // Bundle the ID-side fields as a valid instruction
    always_comb begin
        incoming.rs1   = id_rs1;
        incoming.rs2   = id_rs2;
        incoming.rd    = id_rd;
        incoming.rd1   = id_read_data1;
        incoming.rd2   = id_read_data2;
        incoming.imm   = id_imm;
        incoming.pc    = id_pc;
        incoming.funct = id_funct;
        incoming.ctrl  = id_ctrl;
        incoming.valid = 1'b1;
    end

    // Next state: flush > hold > load-use bubble > load
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (hold) begin
            stage_d = stage_q;
        end else if (hazard_stall) begin
            stage_d = '0;
        end else begin
            stage_d = incoming;
        end
    end

    // Pipeline register, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ID_EX_Rs1       = stage_q.rs1;
    assign ID_EX_Rs2       = stage_q.rs2;
    assign ID_EX_Rd        = stage_q.rd;
    assign ID_EX_ReadData1 = stage_q.rd1;
    assign ID_EX_ReadData2 = stage_q.rd2;
    assign ID_EX_Imm       = stage_q.imm;
    assign ID_EX_PC        = stage_q.pc;
    assign ID_EX_Funct     = stage_q.funct;
    assign ID_EX_Ctrl      = stage_q.ctrl;
    assign ID_EX_Valid     = stage_q.valid;

endmodule
